montgomery_mult_param: RTL

//  Parametrised radix-2 Montgomery multiplier. Computes result = A*B*2^-WIDTH mod M, fully reduced.

---
 rtl/mont_pkg.sv | 21 ++
 rtl/mont_addsub.sv | 17 +
 rtl/montgomery_mult_param.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mont_pkg.sv
// Shared types for the radix-2 Montgomery multiplier: FSM state encoding and
// the addend-select codes formed from {a_i, q}.
package mont_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        ITER = 3'd2,
        SUB  = 3'd3,
        HOLD = 3'd4
    } state_t;

    // Addend chosen each iteration; the code is exactly {a_i, q}.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'b00,
        SEL_M    = 2'b01,
        SEL_B    = 2'b10,
        SEL_BM   = 2'b11
    } addend_sel_t;

endpackage

// File: rtl/mont_addsub.sv
// Combinational W-bit adder/subtractor; subtraction is x + ~y + 1 so the
// block needs only one carry chain.
module mont_addsub #(
    parameter int W = 514
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         sub,
    output logic [W-1:0] sum
);

    logic [W-1:0] y_eff;

    assign y_eff = sub ? ~y : y;
    assign sum   = x + y_eff + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/montgomery_mult_param.sv
// Radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M, fully reduced,
// with valid/ready handshakes and a single shared adder for PRE/ITER/SUB.
module montgomery_mult_param
    import mont_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             busy
);

    localparam int AW = WIDTH + 2;

    state_t            state;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  m_reg;
    logic [WIDTH:0]    bm_reg;
    logic [WIDTH:0]    c_reg;
    logic [CNT_W-1:0]  cnt;

    logic              a_bit;
    logic              q_bit;
    addend_sel_t       sel;
    logic [AW-1:0]     op_x;
    logic [AW-1:0]     op_y;
    logic              op_sub;
    logic [AW-1:0]     sum;

    assign a_bit = a_sh[0];
    assign q_bit = c_reg[0] ^ (a_bit & b_reg[0]);
    assign sel   = addend_sel_t'({a_bit, q_bit});

    // Operand mux in front of the one adder: B+M in PRE, C-M in SUB,
    // C+addend otherwise (only consumed in ITER).
    always_comb begin
        op_x   = {1'b0, c_reg};
        op_y   = '0;
        op_sub = 1'b0;
        case (state)
            PRE: begin
                op_x = {2'b00, b_reg};
                op_y = {2'b00, m_reg};
            end
            SUB: begin
                op_y   = {2'b00, m_reg};
                op_sub = 1'b1;
            end
            default: begin
                case (sel)
                    SEL_B:   op_y = {2'b00, b_reg};
                    SEL_M:   op_y = {2'b00, m_reg};
                    SEL_BM:  op_y = {1'b0, bm_reg};
                    default: op_y = '0;
                endcase
            end
        endcase
    end

    mont_addsub #(.W(AW)) u_addsub (
        .x   (op_x),
        .y   (op_y),
        .sub (op_sub),
        .sum (sum)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            c_reg     <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_sh     <= in_a;
                        b_reg    <= in_b;
                        m_reg    <= in_m;
                        c_reg    <= '0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= PRE;
                    end
                end
                PRE: begin
                    bm_reg <= sum[WIDTH:0];
                    state  <= ITER;
                end
                ITER: begin
                    // C < 2M always, so the halved sum fits in WIDTH+1 bits.
                    c_reg <= sum[WIDTH+1:1];
                    a_sh  <= a_sh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= SUB;
                end
                SUB: begin
                    result    <= sum[AW-1] ? c_reg[WIDTH-1:0] : sum[WIDTH-1:0];
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
